// File: rtl/ioctl_multiseg_loader.sv
// Simulation-side HPS ioctl download generator: streams a table of segments
// from a req/valid byte source onto a core's ioctl download port.
module ioctl_multiseg_loader #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_SEGMENTS = 2,
  parameter int unsigned WR_INTERVAL  = 6,
  parameter int unsigned PRE_CYCLES   = 192,
  parameter int unsigned GAP_CYCLES   = 128
) (
  input  logic                       i_HPSIO_CLK,
  input  logic                       i_RST,
  input  logic                       i_START,
  input  logic [16*NUM_SEGMENTS-1:0] i_SEG_INDEX,
  input  logic [32*NUM_SEGMENTS-1:0] i_SEG_LEN,
  output logic                       o_SRC_REQ,
  input  logic                       i_SRC_VALID,
  input  logic [7:0]                 i_SRC_DATA,
  output logic                       o_IOCTL_DOWNLOAD,
  output logic [15:0]                o_IOCTL_INDEX,
  output logic [26:0]                o_IOCTL_ADDR,
  output logic [DATA_WIDTH-1:0]      o_IOCTL_DATA,
  output logic                       o_IOCTL_WR,
  input  logic                       i_IOCTL_WAIT,
  output logic                       o_BUSY,
  output logic                       o_DONE,
  output logic [2:0]                 o_SEG_NUM
);

  localparam int unsigned BPW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_FETCH, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_cnt;
  logic [31:0]           r_rem;
  logic [1:0]            r_bcnt;
  logic [2:0]            r_seg;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_download;
  logic [15:0]           r_index;
  logic [26:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_req, w_take, w_word_full, w_last_seg, w_enter_pre;
  logic [31:0]           w_rem_nxt;
  logic [1:0]            w_bcnt_nxt;
  logic [2:0]            w_pre_seg;
  logic [DATA_WIDTH-1:0] w_word_nxt;
  logic [15:0]           w_seg_index;
  logic [31:0]           w_seg_len;

  // A word is complete once bpw bytes are in or the segment has run dry;
  // unfilled upper bytes keep the 0xFF preset of r_word.
  assign w_req       = (r_state == S_FETCH) && (32'(r_bcnt) < BPW) && (r_rem != '0);
  assign w_take      = w_req && i_SRC_VALID;
  assign w_rem_nxt   = r_rem - 32'(w_take);
  assign w_bcnt_nxt  = r_bcnt + 2'(w_take);
  assign w_word_full = (32'(w_bcnt_nxt) >= BPW) || (w_rem_nxt == '0);
  assign w_last_seg  = (32'(r_seg) == NUM_SEGMENTS - 1);
  assign w_pre_seg   = (r_state == S_GAP) ? r_seg + 3'd1 : '0;
  assign w_enter_pre = (w_state_nxt == S_PRE) && (r_state != S_PRE);

  always_comb begin
    w_word_nxt = r_word;
    if (w_take) begin
      for (int unsigned b = 0; b < BPW; b++) begin
        if (32'(r_bcnt) == b) w_word_nxt[8*b +: 8] = i_SRC_DATA;
      end
    end
  end

  always_comb begin
    w_seg_index = '0;
    w_seg_len   = '0;
    for (int unsigned n = 0; n < NUM_SEGMENTS; n++) begin
      if (32'(w_pre_seg) == n) begin
        w_seg_index = i_SEG_INDEX[16*n +: 16];
        w_seg_len   = i_SEG_LEN[32*n +: 32];
      end
    end
  end

  always_ff @(posedge i_HPSIO_CLK or posedge i_RST) begin
    if (i_RST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_START) w_state_nxt = S_PRE;
      S_PRE:
        if (!i_IOCTL_WAIT && r_cnt == PRE_CYCLES - 1)
          w_state_nxt = (r_rem != '0) ? S_FETCH : S_GAP;
      S_FETCH:  if (w_word_full && !i_IOCTL_WAIT) w_state_nxt = S_SETUP;
      S_SETUP:  if (!i_IOCTL_WAIT) w_state_nxt = S_STROBE;
      // The strobe always advances so WR is never stretched by wait.
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD:
        if (!i_IOCTL_WAIT && r_cnt == WR_INTERVAL - 1)
          w_state_nxt = (r_rem != '0) ? S_FETCH : S_GAP;
      S_GAP:
        if (!i_IOCTL_WAIT && r_cnt == GAP_CYCLES - 1)
          w_state_nxt = w_last_seg ? S_DONE : S_PRE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_HPSIO_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_bcnt     <= '0;
      r_seg      <= '0;
      r_word     <= '1;
      r_download <= 1'b0;
      r_index    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (!i_IOCTL_WAIT) r_cnt <= r_cnt + 1;
      if ((w_state_nxt != r_state) && (w_state_nxt inside {S_PRE, S_SETUP, S_GAP}))
        r_cnt <= '0;

      if (w_enter_pre) begin
        r_seg      <= w_pre_seg;
        r_index    <= w_seg_index;
        r_addr     <= '0;
        r_rem      <= w_seg_len;
        r_download <= 1'b1;
        r_bcnt     <= '0;
        r_word     <= '1;
      end

      if (r_state == S_FETCH) begin
        r_rem <= w_rem_nxt;
        if (w_state_nxt == S_SETUP) begin
          r_data <= w_word_nxt;
          r_word <= '1;
          r_bcnt <= '0;
        end else begin
          r_word <= w_word_nxt;
          r_bcnt <= w_bcnt_nxt;
        end
      end

      if ((r_state == S_HOLD) && (w_state_nxt != S_HOLD))
        r_addr <= r_addr + 27'(BPW);

      if ((w_state_nxt == S_GAP) && (r_state != S_GAP))
        r_download <= 1'b0;

      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        r_download <= 1'b0;
        r_addr     <= '0;
        r_data     <= '0;
        r_index    <= '0;
      end
    end
  end

  assign o_SRC_REQ        = w_req;
  assign o_IOCTL_DOWNLOAD = r_download;
  assign o_IOCTL_INDEX    = r_index;
  assign o_IOCTL_ADDR     = r_addr;
  assign o_IOCTL_DATA     = r_data;
  assign o_IOCTL_WR       = (r_state == S_STROBE);
  assign o_BUSY           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_DONE           = (r_state == S_DONE);
  assign o_SEG_NUM        = r_seg;

endmodule

// File: tb/tb_ioctl_multiseg_loader.sv
// Directed bench for ioctl_multiseg_loader: an 8-bit single-segment instance
// and a 16-bit two-segment instance, each fed by a small byte-source model.
module tb_ioctl_multiseg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: 8-bit, one segment
  logic        a_start, a_wait, a_req, a_valid, a_dl, a_wr, a_busy, a_done;
  logic [15:0] a_idx, a_index;
  logic [31:0] a_len;
  logic [7:0]  a_sdata, a_data;
  logic [26:0] a_addr;
  logic [2:0]  a_seg;

  // Instance B: 16-bit, two segments
  logic        b_start, b_wait, b_req, b_valid, b_dl, b_wr, b_busy, b_done;
  logic [31:0] b_idx;
  logic [63:0] b_len;
  logic [15:0] b_index, b_data;
  logic [7:0]  b_sdata;
  logic [26:0] b_addr;
  logic [2:0]  b_seg;

  ioctl_multiseg_loader #(
    .DATA_WIDTH(8), .NUM_SEGMENTS(1), .WR_INTERVAL(6), .PRE_CYCLES(4), .GAP_CYCLES(3)
  ) u_a (
    .i_HPSIO_CLK(clk), .i_RST(rst), .i_START(a_start),
    .i_SEG_INDEX(a_idx), .i_SEG_LEN(a_len),
    .o_SRC_REQ(a_req), .i_SRC_VALID(a_valid), .i_SRC_DATA(a_sdata),
    .o_IOCTL_DOWNLOAD(a_dl), .o_IOCTL_INDEX(a_index), .o_IOCTL_ADDR(a_addr),
    .o_IOCTL_DATA(a_data), .o_IOCTL_WR(a_wr), .i_IOCTL_WAIT(a_wait),
    .o_BUSY(a_busy), .o_DONE(a_done), .o_SEG_NUM(a_seg)
  );

  ioctl_multiseg_loader #(
    .DATA_WIDTH(16), .NUM_SEGMENTS(2), .WR_INTERVAL(6), .PRE_CYCLES(4), .GAP_CYCLES(128)
  ) u_b (
    .i_HPSIO_CLK(clk), .i_RST(rst), .i_START(b_start),
    .i_SEG_INDEX(b_idx), .i_SEG_LEN(b_len),
    .o_SRC_REQ(b_req), .i_SRC_VALID(b_valid), .i_SRC_DATA(b_sdata),
    .o_IOCTL_DOWNLOAD(b_dl), .o_IOCTL_INDEX(b_index), .o_IOCTL_ADDR(b_addr),
    .o_IOCTL_DATA(b_data), .o_IOCTL_WR(b_wr), .i_IOCTL_WAIT(b_wait),
    .o_BUSY(b_busy), .o_DONE(b_done), .o_SEG_NUM(b_seg)
  );

  // Byte sources
  logic [7:0] mem_a [0:15];
  logic [7:0] mem_b [0:15];
  int   a_ptr, b_ptr;
  logic a_clr, b_clr, a_tog_mode, a_tog;

  always @(posedge clk) begin
    if (a_clr) begin
      a_ptr <= 0;
      a_tog <= 1'b0;
    end else begin
      a_tog <= ~a_tog;
      if (a_req && a_valid) a_ptr <= a_ptr + 1;
    end
    if (b_clr) b_ptr <= 0;
    else if (b_req && b_valid) b_ptr <= b_ptr + 1;
  end

  assign a_valid = a_tog_mode ? a_tog : 1'b1;
  assign b_valid = 1'b1;
  assign a_sdata = mem_a[a_ptr[3:0]];
  assign b_sdata = mem_b[b_ptr[3:0]];

  // Write log and protocol monitors
  typedef struct packed {
    logic [26:0] addr;
    logic [15:0] data;
    logic [15:0] index;
    logic [2:0]  seg;
    logic [31:0] cyc;
  } wr_t;

  wr_t  a_log [0:127];
  wr_t  b_log [0:127];
  int   a_n = 0, b_n = 0, cyc = 0;
  int   a_err = 0, b_err = 0, b_idx_err = 0, a_dl_cnt = 0;
  int   b_low = 0, b_gap_last = 0, b_rises = 0;
  logic a_wr_q = 1'b0, b_wr_q = 1'b0, b_dl_q = 1'b0;
  logic [15:0] b_index_q = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_wr) begin
      a_log[a_n[6:0]] = '{a_addr, {8'h00, a_data}, a_index, a_seg, 32'(cyc)};
      a_n = a_n + 1;
      if (a_wr_q) a_err = a_err + 1;
    end
    if (a_req && !(a_busy && a_dl && !a_wr)) a_err = a_err + 1;
    if (a_dl) a_dl_cnt = a_dl_cnt + 1;
    a_wr_q = a_wr;

    if (b_wr) begin
      b_log[b_n[6:0]] = '{b_addr, b_data, b_index, b_seg, 32'(cyc)};
      b_n = b_n + 1;
      if (b_wr_q) b_err = b_err + 1;
    end
    if (b_req && !(b_busy && b_dl && !b_wr)) b_err = b_err + 1;
    if ((b_index != b_index_q) && b_dl_q) b_idx_err = b_idx_err + 1;
    if (!b_busy) b_low = 0;
    else if (!b_dl) b_low = b_low + 1;
    if (b_dl && !b_dl_q) begin
      b_gap_last = b_low;
      b_low      = 0;
      b_rises    = b_rises + 1;
    end
    b_wr_q    = b_wr;
    b_dl_q    = b_dl;
    b_index_q = b_index;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [26:0] addr;
    logic [15:0] data;
    logic [15:0] index;
    logic [2:0]  seg;
    int          cyc;   // cycles after the START edge, -1 = not checked
  } exp_t;

  exp_t exp_q [$];

  function automatic exp_t mk(input logic [26:0] a, input logic [15:0] d,
                              input logic [15:0] ix, input logic [2:0] s, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.index = ix; e.seg = s; e.cyc = c;
    return e;
  endfunction

  task automatic cmp_writes(input string tag, input bit use_b, input int base, input int t0);
    int   n;
    wr_t  w;
    exp_t e;
    n = use_b ? (b_n - base) : (a_n - base);
    chk({tag, "_wr_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      w = use_b ? b_log[base + i] : a_log[base + i];
      e = exp_q[i];
      chk($sformatf("%s_wr%0d_fields", tag, i), 64'({w.addr, w.data, w.index, w.seg}),
          64'({e.addr, e.data, e.index, e.seg}));
      if (e.cyc >= 0)
        chk($sformatf("%s_wr%0d_cycle", tag, i), 64'(int'(w.cyc) - t0), 64'(e.cyc));
    end
  endtask

  task automatic wait_done(input string tag, input bit use_b, input int budget);
    int n = 0;
    while (!(use_b ? b_done : a_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_reached"}, 64'(use_b ? b_done : a_done), 64'd1);
  endtask

  // Clears the source, then pulses START; returns 1 ns after the START edge.
  task automatic pulse_start(input bit use_b, output int t0);
    @(posedge clk); #1;
    if (use_b) b_clr = 1'b1; else a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0; b_clr = 1'b0;
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t0, base, dl0, ptr0;
    rst = 1'b1;
    a_start = 0; a_wait = 0; a_idx = '0; a_len = '0; a_clr = 1; a_tog_mode = 0;
    b_start = 0; b_wait = 0; b_idx = '0; b_len = '0; b_clr = 1;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'hA0 + 8'(i);
      mem_b[i] = 8'h11 * 8'(i + 1);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    a_clr = 0; b_clr = 0;
    @(negedge clk);
    chk("reset_a_outputs", 64'({a_dl, a_index, a_addr, a_data, a_wr, a_req, a_busy, a_done, a_seg}), 64'd0);
    chk("reset_b_outputs", 64'({b_dl, b_index, b_addr, b_data, b_wr, b_req, b_busy, b_done, b_seg}), 64'd0);

    // A1: len 4, always valid; START again mid-stream must be ignored
    exp_q = '{mk(0, 16'h00A0, 16'h0007, 0, 7), mk(1, 16'h00A1, 16'h0007, 0, 14),
              mk(2, 16'h00A2, 16'h0007, 0, 21), mk(3, 16'h00A3, 16'h0007, 0, 28)};
    a_idx = 16'h0007; a_len = 32'd4;
    base = a_n; dl0 = a_dl_cnt;
    pulse_start(1'b0, t0);
    repeat (10) @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    wait_done("a1", 1'b0, 200);
    cmp_writes("a1", 1'b0, base, t0);
    chk("a1_src_consumed", 64'(a_ptr), 64'd4);
    chk("a1_download_cycles", 64'(a_dl_cnt - dl0), 64'd32);
    chk("a1_done_outputs", 64'({a_dl, a_index, a_addr, a_data, a_busy}), 64'd0);

    // A2: wait for 10 cycles mid-HOLD, then for 10 cycles starting at STROBE
    exp_q = '{mk(0, 16'h00A0, 16'h0011, 0, 7), mk(1, 16'h00A1, 16'h0011, 0, 24),
              mk(2, 16'h00A2, 16'h0011, 0, 41)};
    a_idx = 16'h0011; a_len = 32'd3;
    base = a_n;
    pulse_start(1'b0, t0);
    repeat (8) @(posedge clk);
    #1 a_wait = 1'b1;
    repeat (10) @(posedge clk);
    #1 a_wait = 1'b0;
    repeat (5) @(posedge clk);
    #1 a_wait = 1'b1;
    repeat (10) @(posedge clk);
    #1 a_wait = 1'b0;
    wait_done("a2", 1'b0, 200);
    cmp_writes("a2", 1'b0, base, t0);
    chk("a2_src_consumed", 64'(a_ptr), 64'd3);

    // A3: VALID toggles every other cycle
    exp_q = '{mk(0, 16'h00A0, 16'h0022, 0, -1), mk(1, 16'h00A1, 16'h0022, 0, -1),
              mk(2, 16'h00A2, 16'h0022, 0, -1), mk(3, 16'h00A3, 16'h0022, 0, -1),
              mk(4, 16'h00A4, 16'h0022, 0, -1)};
    a_idx = 16'h0022; a_len = 32'd5; a_tog_mode = 1'b1;
    base = a_n;
    pulse_start(1'b0, t0);
    wait_done("a3", 1'b0, 300);
    a_tog_mode = 1'b0;
    cmp_writes("a3", 1'b0, base, t0);
    chk("a3_src_consumed", 64'(a_ptr), 64'd5);

    // A4: zero-length segment gives a download pulse without writes
    a_idx = 16'h0009; a_len = 32'd0;
    base = a_n; dl0 = a_dl_cnt;
    pulse_start(1'b0, t0);
    @(negedge clk);
    chk("a4_pre_dl_index", 64'({a_dl, a_index, a_busy}), 64'({1'b1, 16'h0009, 1'b1}));
    wait_done("a4", 1'b0, 100);
    chk("a4_no_writes", 64'(a_n - base), 64'd0);
    chk("a4_download_cycles", 64'(a_dl_cnt - dl0), 64'd4);
    chk("a4_src_consumed", 64'(a_ptr), 64'd0);

    // A5: reset asserted in HOLD after the first write
    a_idx = 16'h0033; a_len = 32'd4;
    base = a_n;
    pulse_start(1'b0, t0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("a5_reset_outputs", 64'({a_dl, a_index, a_addr, a_data, a_wr, a_req, a_busy, a_done, a_seg}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("a5_writes_before_reset_only", 64'(a_n - base), 64'd1);
    chk("a5_idle_after_reset", 64'({a_busy, a_done, a_dl}), 64'd0);
    chk("a_wr_width_req_protocol", 64'(a_err), 64'd0);

    // B1: 16-bit, len 3 (odd tail padded with 0xFF), then a zero-length segment
    exp_q = '{mk(0, 16'h2211, 16'h0005, 0, 8), mk(2, 16'hFF33, 16'h0005, 0, -1)};
    b_idx = {16'h0006, 16'h0005}; b_len = {32'd0, 32'd3};
    base = b_n; ptr0 = b_rises;
    pulse_start(1'b1, t0);
    wait_done("b1", 1'b1, 1000);
    cmp_writes("b1", 1'b1, base, t0);
    chk("b1_src_consumed", 64'(b_ptr), 64'd3);
    chk("b1_download_pulses", 64'(b_rises - ptr0), 64'd2);

    // B2: index 0 len 2, then index 254 len 9
    exp_q = '{mk(0, 16'h2211, 16'd0, 0, 8),
              mk(0, 16'h4433, 16'd254, 1, -1), mk(2, 16'h6655, 16'd254, 1, -1),
              mk(4, 16'h8877, 16'd254, 1, -1), mk(6, 16'hAA99, 16'd254, 1, -1),
              mk(8, 16'hFFBB, 16'd254, 1, -1)};
    b_idx = {16'd254, 16'd0}; b_len = {32'd9, 32'd2};
    base = b_n;
    pulse_start(1'b1, t0);
    wait_done("b2", 1'b1, 1000);
    cmp_writes("b2", 1'b1, base, t0);
    chk("b2_src_consumed", 64'(b_ptr), 64'd11);
    chk("b2_gap_low_cycles", 64'(b_gap_last), 64'd128);
    chk("b2_done_outputs", 64'({b_dl, b_index, b_addr, b_data}), 64'd0);
    chk("b_index_change_with_download_high", 64'(b_idx_err), 64'd0);
    chk("b_wr_width_req_protocol", 64'(b_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ioctl_multiseg_loader.md
# ioctl_multiseg_loader

Parametrised simulation-side HPS ioctl download generator; drives a core's `ioctl_*` download port exactly as the MiSTer HPS does.
- Streams a programmable list of segments (ROM image, DIP-switch block, NVRAM, …), each with its own `ioctl_index` and byte length.
- Ioctl data is 8 or 16 bits wide.
- Bytes come from an external byte source over a req/valid handshake, so file I/O stays in a thin bench wrapper.
- Sits in the sim top between the byte-source wrapper and the core's ioctl inputs; honours `ioctl_wait` at every step.

## Interface
- `DATA_WIDTH`, 8: ioctl data width; 8 or 16.
- `NUM_SEGMENTS`, 2: number of segments streamed per start; 1–8.
- `WR_INTERVAL`, 6: cycles per word from SETUP entry to address increment; ≥3.
- `PRE_CYCLES`, 192: cycles with download high before the first word of a segment.
- `GAP_CYCLES`, 128: cycles with download low after each segment.

Ports:
- `i_HPSIO_CLK`  in  1  sole clock.
- `i_RST`  in  1  asynchronous, active-high reset.
- `i_START`  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- `i_SEG_INDEX`  in  16*NUM_SEGMENTS  per-segment ioctl index; segment n = bits [16n+15:16n].
- `i_SEG_LEN`  in  32*NUM_SEGMENTS  per-segment length in bytes.
- `o_SRC_REQ`  out  1  byte request; high only in FETCH.
- `i_SRC_VALID`  in  1  byte present on `i_SRC_DATA`.
- `i_SRC_DATA`  in  8  source byte.
- `o_IOCTL_DOWNLOAD`  out  1  ioctl download.
- `o_IOCTL_INDEX`  out  16  ioctl index.
- `o_IOCTL_ADDR`  out  27  ioctl byte address.
- `o_IOCTL_DATA`  out  DATA_WIDTH  ioctl data.
- `o_IOCTL_WR`  out  1  one-cycle write strobe.
- `i_IOCTL_WAIT`  in  1  core back-pressure.
- `o_BUSY`  out  1  high in any state other than IDLE or DONE.
- `o_DONE`  out  1  high in DONE.
- `o_SEG_NUM`  out  3  current segment number.

## Operation
- **States:** IDLE, PRE, FETCH, SETUP, STROBE, HOLD, GAP, DONE.
- **Start:** IDLE/DONE + `i_START` → PRE with seg=0.
  - On PRE entry: INDEX←`i_SEG_INDEX[seg]`, ADDR←0, remaining←`i_SEG_LEN[seg]`, DOWNLOAD←1.
- **PRE:** count `PRE_CYCLES`.
  - Then → FETCH if remaining>0.
  - Otherwise → GAP (zero-length segment: download pulse, no WR).
- **FETCH:** assemble bpw = DATA_WIDTH/8 bytes.
  - Each edge with REQ&VALID consumes one byte; little-endian (first byte in [7:0]).
  - remaining decrements per byte consumed.
  - 16-bit with odd remaining: last word upper byte = 0xFF, not fetched.
  - On the edge completing the word: DATA←word, → SETUP.
- **SETUP** (1 cycle) → **STROBE:** WR high exactly this one cycle → **HOLD**.
  - HOLD lasts until `WR_INTERVAL` cycles since SETUP entry.
  - On the last HOLD cycle: ADDR += bpw; → FETCH if remaining>0, else → GAP.
- **GAP:** DOWNLOAD←0 on entry; count `GAP_CYCLES`.
  - Then seg+1 → PRE, or → DONE after the last segment.
  - INDEX changes only on PRE entry, i.e. while DOWNLOAD is low.
- **Wait:** `i_IOCTL_WAIT` high freezes PRE, SETUP, STROBE, HOLD and GAP counters and state.
  - WR is never held: if wait rises during STROBE, WR still drops next cycle and the strobe is not repeated.
  - FETCH is not frozen by wait, but exits to SETUP only with wait low.
- **DONE:** outputs hold; ADDR←0, DATA←0, INDEX←0, DOWNLOAD=0.
- `i_START` in any busy state is ignored.
- Segment table inputs are sampled only on PRE entry; they may change freely otherwise.
- Lengths count bytes; remaining is 32-bit unsigned; ADDR wraps modulo 2^27.

## Timing
- **Reset values:** DOWNLOAD=0, INDEX=0, ADDR=0, DATA=0, WR=0, SRC_REQ=0, BUSY=0, DONE=0, SEG_NUM=0; state IDLE.
- Reset mid-stream returns to IDLE immediately; no trailing WR.
- **Latency:** first WR occurs PRE_CYCLES + bpw + 2 cycles after the START edge, with a zero-wait, always-valid source.
- **Word period:** bpw + WR_INTERVAL cycles, plus source stall cycles, plus wait cycles.
- DATA and ADDR are stable from SETUP entry through end of HOLD; setup to WR ≥1 cycle.
- DOWNLOAD falls on the cycle after the last HOLD cycle of a segment.

## Test plan
- **8-bit, 1 segment, len 4, source always valid, WR_INTERVAL 6, no wait:** 4 WR pulses spaced 7 cycles; ADDR 0,1,2,3; DATA = source bytes; DONE after GAP.
- **16-bit, len 3, bytes 11 22 33:** WR with 0x2211 @ADDR0, then 0xFF33 @ADDR2; exactly 3 SRC consumptions.
- **Wait high 10 cycles mid-HOLD and once during STROBE:** word period grows by 10; each word written exactly once; WR width always 1.
- **2 segments, index 0 (len 2) then 254 (len 9):** DOWNLOAD low for 128 cycles between; INDEX switches 0→254 only while DOWNLOAD is low; ADDR restarts at 0.
- **VALID toggling every other cycle:** no bytes dropped or duplicated; REQ high only in FETCH.
- **Zero-length segment; START while busy; reset asserted mid-HOLD:**
  - zero-length: DOWNLOAD pulse with no WR;
  - START while busy: ignored;
  - reset: all outputs at reset values immediately, no WR after.
